// File: rtl/hp_pkg.sv
// Shared types and constants for the HP controller: state encoding, HP range
// and the saturating HP arithmetic used by every state.
package hp_pkg;

  localparam int HP_W = 3;
  localparam logic [HP_W-1:0] MAX_HP = 3'd7;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hp_state_t;

  // Sum is formed one bit wider so a large heal can never wrap past MAX_HP.
  function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] a,
                                              input logic [HP_W:0]   b);
    logic [HP_W:0] sum;
    sum = {1'b0, a} + b;
    return (sum > {1'b0, MAX_HP}) ? MAX_HP : sum[HP_W-1:0];
  endfunction

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter advanced by the frame tick; a load always wins over a
// decrement in the same cycle, and the count rests at zero.
module tick_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hp_controller.sv
// Player hit-point controller: damage, healing, slow regeneration, a post-hit
// invulnerability window and a timed respawn, all with registered outputs.
module hp_controller
  import hp_pkg::*;
#(
  parameter int INVULN_TICKS  = 16,
  parameter int REGEN_TICKS   = 64,
  parameter int RESPAWN_TICKS = 32
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            tick,
  input  logic            damage,
  input  logic [HP_W-1:0] damage_amt,
  input  logic            heal,
  input  logic [HP_W-1:0] heal_amt,
  output logic [HP_W-1:0] hp,
  output logic            dead,
  output logic            invuln,
  output logic            hp_changed
);

  localparam int TMAX = (INVULN_TICKS > RESPAWN_TICKS) ? INVULN_TICKS : RESPAWN_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(REGEN_TICKS + 1);

  hp_state_t       state, state_next;
  logic [HP_W-1:0] hp_next;
  logic [RW-1:0]   regen_cnt, regen_next;
  logic            regen_step;
  logic            tmr_load;
  logic [TW-1:0]   tmr_load_val, tmr_count;
  logic            tmr_zero, expire;
  logic            dmg_ok, heal_ok;

  assign dmg_ok  = damage && (damage_amt != '0);
  assign heal_ok = heal && (heal_amt != '0);
  // The window closes on the tick that takes the timer to zero.
  assign expire  = tmr_zero || (tick && (tmr_count == TW'(1)));

  tick_timer #(.W(TW)) u_timer (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tick),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next   = state;
    hp_next      = hp;
    regen_next   = '0;
    regen_step   = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state)
      ALIVE: begin
        if (dmg_ok) begin
          hp_next  = sat_sub(hp, damage_amt);
          tmr_load = 1'b1;
          if (hp_next == '0) begin
            state_next   = DEAD;
            tmr_load_val = TW'(RESPAWN_TICKS);
          end else begin
            state_next   = INVULN;
            tmr_load_val = TW'(INVULN_TICKS);
          end
        end else begin
          if (hp != MAX_HP) begin
            if (!tick) begin
              regen_next = regen_cnt;
            end else if (regen_cnt == RW'(REGEN_TICKS - 1)) begin
              regen_step = 1'b1;
            end else begin
              regen_next = regen_cnt + 1'b1;
            end
          end
          // A heal and a regen step landing together are summed, then saturated.
          hp_next = sat_add(hp, {1'b0, (heal_ok ? heal_amt : 3'd0)} + {3'b000, regen_step});
          if (hp_next == MAX_HP) begin
            regen_next = '0;
          end
        end
      end
      INVULN: begin
        if (heal_ok) begin
          hp_next = sat_add(hp, {1'b0, heal_amt});
        end
        if (expire) begin
          state_next = ALIVE;
        end
      end
      DEAD: begin
        if (expire) begin
          state_next   = INVULN;
          hp_next      = MAX_HP;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(INVULN_TICKS);
        end
      end
      default: state_next = ALIVE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ALIVE;
      hp         <= MAX_HP;
      regen_cnt  <= '0;
      dead       <= 1'b0;
      invuln     <= 1'b0;
      hp_changed <= 1'b0;
    end else begin
      state      <= state_next;
      hp         <= hp_next;
      regen_cnt  <= regen_next;
      dead       <= (state_next == DEAD);
      invuln     <= (state_next == INVULN);
      hp_changed <= (hp_next != hp);
    end
  end

endmodule
